// File: rtl/countdown_arbiter_if.sv
// Request/grant bundle for countdown_arbiter.
// master = requester side (drives req/len/tick), slave = arbiter side.
interface countdown_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic                  tick;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic                  done;
    logic [2:0]            done_id;

    modport master (
        output req, len, tick,
        input  gnt, busy, count, done, done_id
    );

    modport slave (
        input  req, len, tick,
        output gnt, busy, count, done, done_id
    );
endinterface

// File: rtl/countdown_arbiter.sv
// Countdown arbiter: grants one requester at a time, loads its len slice and
// counts it down on tick; pulses done for one cycle when the count expires.
// Optional macro CDA_ROUND_ROBIN_EN selects round-robin arbitration from a
// rotating pointer; when undefined the lowest asserted index wins.
module countdown_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    countdown_arbiter_if.slave  bus
);
    localparam int unsigned IDW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [IDW-1:0]   idx_q, idx_d;

    logic             win_vld;
    logic [IDW-1:0]   win_idx;
    logic [WIDTH-1:0] win_len;
    logic             abort;
    logic             expire;

    // Granted requester dropped its request while counting
    assign abort  = (state_q == S_RUN) && ((bus.req & gnt_q) == '0);
    // Final decrement of the running interval
    assign expire = bus.tick && (count_q == WIDTH'(1));

`ifdef CDA_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] idx_nxt;

    assign idx_nxt = (idx_q == IDW'(NREQ - 1)) ? '0 : idx_q + IDW'(1);

    // Round-robin pick: first asserted req at/after pointer, then wrap
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_len = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld && bus.req[i] && (i >= 32'(ptr_q))) begin
                win_vld = 1'b1;
                win_idx = IDW'(i);
                win_len = bus.len[i*WIDTH +: WIDTH];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld && bus.req[i]) begin
                win_vld = 1'b1;
                win_idx = IDW'(i);
                win_len = bus.len[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves past the granted index on completion or abort
    always_comb begin
        ptr_d = ptr_q;
        if (abort || (state_q == S_DONE)) begin
            ptr_d = idx_nxt;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority pick: lowest asserted index
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_len = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld && bus.req[i]) begin
                win_vld = 1'b1;
                win_idx = IDW'(i);
                win_len = bus.len[i*WIDTH +: WIDTH];
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = (win_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (expire) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values
    always_comb begin
        gnt_d     = gnt_q;
        count_d   = count_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        done_id_d = '0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d   = NREQ'(1) << win_idx;
                    count_d = win_len;
                    idx_d   = win_idx;
                    if (win_len == '0) begin
                        done_d    = 1'b1;
                        done_id_d = win_idx;
                    end
                end else begin
                    gnt_d = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    gnt_d = '0;
                end else if (bus.tick && (count_q != '0)) begin
                    count_d = count_q - WIDTH'(1);
                    if (expire) begin
                        done_d    = 1'b1;
                        done_id_d = idx_q;
                    end
                end
            end
            S_DONE: begin
                gnt_d = '0;
            end
            default: begin
                gnt_d = '0;
            end
        endcase
        busy_d = |gnt_d;
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            idx_q     <= '0;
        end else begin
            gnt_q     <= gnt_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Self-checking bench for countdown_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_countdown_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Reference model: who owns the grant (-1 = nobody), remaining count,
    // whether this cycle is the completion cycle, and the rotation pointer.
    int   m_owner;
    int   m_count;
    bit   m_done;
    int   m_ptr;

    int   done_seq[$];
    int   exp_seq[5];

    countdown_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    countdown_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int w;
        w = -1;
`ifdef CDA_ROUND_ROBIN_EN
        for (int k = 0; k < int'(NREQ); k++) begin
            int c;
            c = (m_ptr + k) % int'(NREQ);
            if (w < 0 && bus.req[c]) w = c;
        end
`else
        for (int k = 0; k < int'(NREQ); k++) begin
            if (w < 0 && bus.req[k]) w = k;
        end
`endif
        return w;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_count = 0;
        m_done  = 1'b0;
        m_ptr   = 0;
    endtask

    task automatic model_step();
        int w;
        if (m_done) begin
            m_done  = 1'b0;
            m_ptr   = (m_owner + 1) % int'(NREQ);
            m_owner = -1;
        end else if (m_owner < 0) begin
            w = pick();
            if (w >= 0) begin
                m_owner = w;
                m_count = int'(bus.len[w*WIDTH +: WIDTH]);
                if (m_count == 0) m_done = 1'b1;
            end
        end else if (!bus.req[m_owner]) begin
            m_ptr   = (m_owner + 1) % int'(NREQ);
            m_owner = -1;
        end else if (bus.tick && m_count > 0) begin
            m_count--;
            if (m_count == 0) m_done = 1'b1;
        end
    endtask

    task automatic check_model();
        logic [NREQ-1:0] eg;
        eg = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        chk("gnt",     32'(bus.gnt),     32'(eg));
        chk("busy",    32'(bus.busy),    32'(m_owner >= 0));
        chk("count",   32'(bus.count),   32'(m_count));
        chk("done",    32'(bus.done),    32'(m_done));
        chk("done_id", 32'(bus.done_id), m_done ? 32'(m_owner) : 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic set_len(input int i, input int v);
        bus.len[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_model();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.len  = '0;
        bus.tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   32'(bus.gnt),     32'd0);
        chk("rst_count", 32'(bus.count),   32'd0);
        chk("rst_done",  32'(bus.done),    32'd0);
        chk("rst_busy",  32'(bus.busy),    32'd0);
        chk("rst_id",    32'(bus.done_id), 32'd0);
        rst = 1'b0;
        cycle();

        // Single requester, len 3, tick every cycle
        bus.req = 4'b0001; set_len(0, 3); bus.tick = 1'b1;
        cycle();
        chk("r030_gnt", 32'(bus.gnt), 32'd1);
        chk("r030_c3",  32'(bus.count), 32'd3);
        cycle();
        chk("r030_c2",  32'(bus.count), 32'd2);
        cycle();
        chk("r030_c1",  32'(bus.count), 32'd1);
        cycle();
        chk("r030_c0",   32'(bus.count), 32'd0);
        chk("r030_done", 32'(bus.done), 32'd1);
        chk("r030_id",   32'(bus.done_id), 32'd0);
        bus.req = '0;
        cycle();
        chk("r030_idle", 32'(bus.gnt), 32'd0);

        // Zero-length load goes straight to completion
        bus.req = 4'b0100; set_len(2, 0);
        cycle();
        chk("r031_gnt",  32'(bus.gnt), 32'd4);
        chk("r031_done", 32'(bus.done), 32'd1);
        chk("r031_id",   32'(bus.done_id), 32'd2);
        bus.req = '0;
        cycle();
        chk("r031_gnt0", 32'(bus.gnt), 32'd0);

        // All requesting, len 1: grant order from fresh reset
        sync_reset();
        for (int i = 0; i < int'(NREQ); i++) set_len(i, 1);
        bus.req = 4'b1111; bus.tick = 1'b1;
        done_seq.delete();
        for (int c = 0; c < 15; c++) begin
            cycle();
            if (bus.done) done_seq.push_back(int'(bus.done_id));
        end
`ifdef CDA_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        chk("r032_n", 32'(done_seq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("r032_order", (i < done_seq.size()) ? 32'(done_seq[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
        end
        bus.req = '0;
        cycle();

        // Abort at count 3, next grant to index 1
        bus.req = 4'b0001; set_len(0, 5); set_len(1, 6);
        cycle();
        cycle();
        cycle();
        chk("r033_c3", 32'(bus.count), 32'd3);
        bus.req = 4'b0010;
        cycle();
        chk("r033_gnt0", 32'(bus.gnt), 32'd0);
        chk("r033_done", 32'(bus.done), 32'd0);
        cycle();
        chk("r033_gnt1", 32'(bus.gnt), 32'd2);
        bus.req = '0;
        cycle();
        cycle();

        // Tick held low keeps the count
        bus.req = 4'b0001; set_len(0, 2); bus.tick = 1'b0;
        cycle();
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("r035_count", 32'(bus.count), 32'd2);
            chk("r035_busy",  32'(bus.busy), 32'd1);
            chk("r035_done",  32'(bus.done), 32'd0);
        end
        bus.tick = 1'b1;
        cycle();
        cycle();
        bus.req = '0;
        cycle();

        // Asynchronous reset mid-interval
        bus.req = 4'b0001; set_len(0, 4); bus.tick = 1'b0;
        cycle();
        chk("r034_c4", 32'(bus.count), 32'd4);
        #3;
        rst = 1'b1;
        #1;
        chk("r034_gnt",   32'(bus.gnt), 32'd0);
        chk("r034_count", 32'(bus.count), 32'd0);
        chk("r034_done",  32'(bus.done), 32'd0);
        chk("r034_busy",  32'(bus.busy), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req = '0;
        cycle();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus.req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
                for (int i = 0; i < int'(NREQ); i++) set_len(i, int'($urandom_range(0, 4)));
            end
            bus.tick = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.req = '0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_arbiter.md
COUNTDOWN_ARBITER -- requirements
Module: countdown_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, countdown width in bits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester level request; held high until done, or dropped to abort.
REQ-006 len  input  NREQ*WIDTH  packed load values; slice i = len[i*WIDTH +: WIDTH].
REQ-007 tick  input  1  decrement enable; one tick = one count step.
REQ-008 gnt  output  NREQ  registered one-hot grant; all-zero when idle.
REQ-009 busy  output  1  high while any grant is held.
REQ-010 count  output  WIDTH  current countdown value.
REQ-011 done  output  1  one-cycle pulse when the granted interval expires.
REQ-012 done_id  output  3  index of the requester that completed; valid with done.

Function
REQ-013 States: IDLE, RUN, DONE; state encoding is free.
REQ-014 IDLE, req nonzero: at the next edge, latch winner into gnt, count <= len slice of winner, go RUN; go DONE instead if that slice is 0.
REQ-015 IDLE, req zero: remain IDLE, gnt = 0, count holds.
REQ-016 RUN: on tick, count <= count-1; if count == 1 and tick, go DONE (count becomes 0).
REQ-017 RUN without tick: count holds.
REQ-018 RUN, granted req bit low: abort; at next edge go IDLE, gnt <= 0, no done pulse, pointer advances past the aborted index.
REQ-019 DONE lasts exactly one cycle: done = 1, done_id = granted index, gnt still held; next edge gnt <= 0, go IDLE.
REQ-020 Pointer after DONE = granted index + 1, modulo NREQ.
REQ-021 Request-to-grant latency is one cycle; a requester that stays high after done gets re-arbitrated from IDLE, at least one idle cycle between grants.
REQ-022 count never wraps: tick with count 0 has no effect.
REQ-023 len and req changes on non-granted indices during RUN have no effect.
REQ-024 busy = |gnt; done and done_id are 0 outside DONE.

Reset
REQ-025 rst forces IDLE, gnt = 0, count = 0, done = 0, done_id = 0, pointer = 0, regardless of clk.
REQ-026 rst asserted mid-RUN discards the interval with no done pulse.
REQ-027 First arbitration after reset release is index 0 first.

Configuration
REQ-028 Macro CDA_ROUND_ROBIN_EN defined: winner is the first asserted req at or after the pointer, scanning upward with wrap.
REQ-029 Macro CDA_ROUND_ROBIN_EN undefined: fixed priority, lowest asserted index wins; pointer unused; all other behaviour identical.

Verification
REQ-030 req = 0001, len0 = 3, tick every cycle -> gnt = 0001 one cycle after req; count 3,2,1,0; done with done_id = 0 on the cycle count reads 0.
REQ-031 req = 0100, len2 = 0 -> one cycle after req, gnt = 0100 with done = 1, done_id = 2; gnt = 0 next cycle.
REQ-032 With CDA_ROUND_ROBIN_EN, req = 1111 held, all len = 1 -> grants in order 0,1,2,3,0; without the macro -> index 0 granted every time.
REQ-033 req0 granted, len0 = 5, req0 dropped at count = 3 -> gnt = 0 next cycle, no done; next grant goes to index 1 if requesting.
REQ-034 rst pulsed asynchronously mid-RUN with count = 4 -> gnt, count, done go 0 immediately; IDLE after release.
REQ-035 tick held low for 10 cycles in RUN with count = 2 -> count stays 2, busy stays 1, no done.
